game_ctrl_param: RTL and testbench
==================================

Name: game_ctrl_param

Overview:
- Parametrised game-state controller for the stickman runner, successor to the single-level, 3-coin controller.
- Sits between the keyboard and frame-counter logic and the colour mapper / background block.
- Generalised coin count, level count, win distance and hitbox geometry.
- Adds a lives/respawn mechanism, a saturating score, key-press edge detection and frame-synchronous collision sampling.

Parameters:
- NUM_COINS, 3, number of coin slots tracked.
- NUM_LEVELS, 2, number of selectable levels (1..9).
- FCW, 12, frame_counter width.
- WIN_FRAME, 3000, frame_counter value at which PLAY is won.
- LIVES, 3, lives at game start (1..15).
- RESPAWN_FRAMES, 60, frame ticks spent in RESPAWN.
- SCORE_W, 8, score width.
- STICK_X, 100, stickman left edge in screen X.
- STICK_H, 50, stickman height.
- FLOOR_Y, 470, fall line.
- HIT_XL, 10 / HIT_XR, 46 / HIT_YT, 10 / HIT_YB, 74: coin hit window offsets, all exclusive.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  ~60 Hz frame strobe (level signal; rising edge detected internally).
- keycode  in  8  last received USB keycode.
- StickmanTop  in  10  stickman top Y.
- GroundY  in  10  ground height under stickman.
- frame_counter  in  FCW  scroll distance in frames.
- CoinFrameX  in  13*NUM_COINS  flattened coin frame-X; slot i is bits [13i+12:13i].
- CoinY  in  10*NUM_COINS  flattened coin Y; slot i is bits [10i+9:10i].
- CoinStatus  out  NUM_COINS  1 = coin i still present.
- level_status  out  NUM_LEVELS  one-hot selected level.
- status  out  5  one-hot {SELECT, WAIT, PLAY, WIN, LOSE}.
- coin_collide  out  1  one-cycle pulse when at least one coin is collected.
- score  out  SCORE_W  coins collected this game.
- lives_left  out  4  remaining lives.
- respawn  out  1  high while in RESPAWN.

Behaviour:
- Reset (Clk edge with Reset=1):
  - state=WAIT, CoinStatus=all 1s, level_status=1 (level 0), score=0, lives_left=LIVES.
  - coin_collide=0, respawn=0; key_prev and frame_prev cleared.
  - Reset mid-game aborts immediately, with no partial score update.
- Edge detection:
  - press(K) = (keycode==K) && (key_prev!=K); key_prev registers keycode every cycle.
  - tick = frame_clk && !frame_prev. All game evaluation happens only on tick cycles.
- States and status encoding: WAIT(01000), SELECT(10000), PLAY(00100), RESPAWN(00100), WIN(00010), LOSE(00001).
- WAIT:
  - Holds CoinStatus=all 1s, score=0, lives_left=LIVES.
  - press(0x2C) -> SELECT.
- SELECT:
  - press(0x1E+i) for i<NUM_LEVELS -> level_status=1<<i, then PLAY.
  - Other keys are ignored.
- PLAY, on tick:
  - dead = (StickmanTop+STICK_H > GroundY) || (StickmanTop+STICK_H >= FLOOR_Y); sums are 11-bit.
  - If dead: lives_left decrements. If the new value is 0 -> LOSE, else -> RESPAWN.
  - Else if frame_counter >= WIN_FRAME -> WIN. Death has priority over win.
  - Coins are evaluated on the same tick only when not dead.
- Coin hit for slot i:
  - left = STICK_X + frame_counter, computed at 14 bits.
  - CoinFrameX zero-extended to 14 bits, with left+HIT_XL < X < left+HIT_XR.
  - And StickmanTop+HIT_YT < Y < StickmanTop+HIT_YB, computed at 11 bits.
  - Only slots with CoinStatus[i]=1 count.
  - Each hit clears CoinStatus[i] on the next cycle.
  - score += number of hits that tick, saturating at 2^SCORE_W-1.
  - coin_collide=1 for exactly that one cycle if the hit count is greater than 0.
- RESPAWN:
  - respawn=1; counts RESPAWN_FRAMES ticks, then -> PLAY.
  - No collision or coin evaluation; CoinStatus and score are held.
- WIN / LOSE:
  - Outputs frozen.
  - press(0x2C) -> WAIT. Holding space does not retrigger SELECT because an edge is required.
- Outputs are all registered; latency from tick to state or output change is 1 Clk.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- When defined:
  - press(0x13) ('P') in PLAY -> PAUSE.
  - PAUSE reports status=00000, ignores ticks, and holds all counters.
  - press(0x13) again -> PLAY; press(0x29) (Esc) -> WAIT.
- When undefined: there is no PAUSE state, and 0x13/0x29 are ignored everywhere.

Test Plan:
- Reset, then idle -> status=01000, CoinStatus=111, level_status=01, lives_left=3, score=0.
- Space held 10 cycles -> exactly one SELECT entry; key 0x1F pressed -> level_status=10, status=00100.
- In PLAY: StickmanTop=400, GroundY=440, tick -> lives_left=2, respawn=1 for 60 ticks, then PLAY. Repeat twice more -> LOSE (00001).
- In PLAY: frame_counter=200, CoinFrameX[1]=320, CoinY[1]=250, StickmanTop=200, tick -> CoinStatus=101, score=1, one-cycle coin_collide. Same inputs on the next tick -> no change.
- frame_counter=3000 while dead condition true -> lives decrement, not WIN. Safe and frame_counter=3000 -> WIN; space press -> WAIT with coins and score restored.
- Score preset near max with SCORE_W=2: three coins collected on one tick -> score saturates at 3. Reset asserted mid-RESPAWN -> WAIT defaults next cycle.

Source files
------------

// File: rtl/game_ctrl_param.sv
// -----------------------------------------------------------------------------
// game_ctrl_param
// Parametrised game-state controller for the stickman runner. Tracks the
// selected level, a set of coin slots, a saturating score and a lives /
// respawn counter. Keys act on their press edge. Game play (death, win and
// coin pickup) is evaluated only on the rising edge of the frame strobe.
//
// Optional build macro: GAME_PAUSE_EN
//   defined   : 'P' (0x13) in PLAY enters PAUSE, 'P' again resumes, Esc (0x29)
//               returns to WAIT. PAUSE reports status 00000.
//   undefined : no PAUSE state. 0x13 and 0x29 are ignored.
//
// Ports
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   frame_clk     in   frame strobe (level). Its rising edge is one game tick.
//   keycode       in   last received USB keycode
//   StickmanTop   in   stickman top Y
//   GroundY       in   ground height under the stickman
//   frame_counter in   scroll distance in frames
//   CoinFrameX    in   flattened coin frame-X, 13 bits per slot
//   CoinY         in   flattened coin Y, 10 bits per slot
//   CoinStatus    out  1 = coin still present
//   level_status  out  one-hot selected level
//   status        out  one-hot {SELECT, WAIT, PLAY, WIN, LOSE}
//   coin_collide  out  one-cycle pulse when a coin is collected
//   score         out  coins collected this game (saturating)
//   lives_left    out  remaining lives
//   respawn       out  high while respawning
// -----------------------------------------------------------------------------
module game_ctrl_param #(
   parameter int NUM_COINS      = 3,
   parameter int NUM_LEVELS     = 2,
   parameter int FCW            = 12,
   parameter int WIN_FRAME      = 3000,
   parameter int LIVES          = 3,
   parameter int RESPAWN_FRAMES = 60,
   parameter int SCORE_W        = 8,
   parameter int STICK_X        = 100,
   parameter int STICK_H        = 50,
   parameter int FLOOR_Y        = 470,
   parameter int HIT_XL         = 10,
   parameter int HIT_XR         = 46,
   parameter int HIT_YT         = 10,
   parameter int HIT_YB         = 74
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    frame_clk,
   input  logic [7:0]              keycode,
   input  logic [9:0]              StickmanTop,
   input  logic [9:0]              GroundY,
   input  logic [FCW-1:0]          frame_counter,
   input  logic [13*NUM_COINS-1:0] CoinFrameX,
   input  logic [10*NUM_COINS-1:0] CoinY,
   output logic [NUM_COINS-1:0]    CoinStatus,
   output logic [NUM_LEVELS-1:0]   level_status,
   output logic [4:0]              status,
   output logic                    coin_collide,
   output logic [SCORE_W-1:0]      score,
   output logic [3:0]              lives_left,
   output logic                    respawn
);

   localparam int RCW  = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES + 1) : 1;
   localparam int HCW  = $clog2(NUM_COINS + 1);
   localparam int SUMW = SCORE_W + HCW + 1;

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_LVL0  = 8'h1E;
`ifdef GAME_PAUSE_EN
   localparam logic [7:0] KEY_P     = 8'h13;
   localparam logic [7:0] KEY_ESC   = 8'h29;
`endif

   localparam logic [SUMW-1:0] SCORE_MAX = {{(SUMW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

   typedef enum logic [2:0] {
      ST_WAIT    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_PLAY    = 3'd2,
      ST_RESPAWN = 3'd3,
      ST_WIN     = 3'd4,
      ST_LOSE    = 3'd5,
      ST_PAUSE   = 3'd6
   } state_t;

   // RESPAWN shares the PLAY code so the colour mapper keeps drawing the level.
   function automatic logic [4:0] status_of(input state_t s);
      logic [4:0] code;
      case (s)
         ST_WAIT:    code = 5'b01000;
         ST_SELECT:  code = 5'b10000;
         ST_PLAY:    code = 5'b00100;
         ST_RESPAWN: code = 5'b00100;
         ST_WIN:     code = 5'b00010;
         ST_LOSE:    code = 5'b00001;
         default:    code = 5'b00000;
      endcase
      return code;
   endfunction

   state_t                state_r, state_next_s;
   logic [NUM_COINS-1:0]  coin_status_r, coin_next_s;
   logic [NUM_LEVELS-1:0] level_r, level_next_s;
   logic [SCORE_W-1:0]    score_r, score_next_s;
   logic [3:0]            lives_r, lives_next_s, lives_dec_s;
   logic [RCW-1:0]        resp_cnt_r, resp_cnt_next_s;
   logic                  collide_r, collide_next_s;
   logic [4:0]            status_r;
   logic                  respawn_r;
   logic [7:0]            key_prev_r;
   logic                  frame_prev_r;

   logic                  tick_s, press_space_s, pause_key_s, esc_key_s;
   logic [NUM_LEVELS-1:0] sel_vec_s;
   logic [10:0]           top_s, feet_s;
   logic                  dead_s, win_s;
   logic [13:0]           left_s;
   logic [NUM_COINS-1:0]  hit_s;
   logic [HCW-1:0]        hit_cnt_s;
   logic [SUMW-1:0]       score_sum_s;
   logic [SCORE_W-1:0]    score_sat_s;

   assign tick_s        = frame_clk && !frame_prev_r;
   assign press_space_s = (keycode == KEY_SPACE) && (key_prev_r != KEY_SPACE);
`ifdef GAME_PAUSE_EN
   assign pause_key_s   = (keycode == KEY_P) && (key_prev_r != KEY_P);
   assign esc_key_s     = (keycode == KEY_ESC) && (key_prev_r != KEY_ESC);
`else
   assign pause_key_s   = 1'b0;
   assign esc_key_s     = 1'b0;
`endif

   // Death sums are taken at 11 bits so a stickman near the bottom cannot wrap.
   assign top_s  = {1'b0, StickmanTop};
   assign feet_s = top_s + 11'(STICK_H);
   assign dead_s = (feet_s > {1'b0, GroundY}) || (feet_s >= 11'(FLOOR_Y));
   assign win_s  = 32'(frame_counter) >= 32'(WIN_FRAME);
   assign left_s = 14'(STICK_X) + 14'(frame_counter);

   // Level-select key press decode, one bit per selectable level.
   always_comb begin
      sel_vec_s = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         sel_vec_s[i] = (keycode == 8'(KEY_LVL0 + i)) && (key_prev_r != 8'(KEY_LVL0 + i));
      end
   end

   // Coin hit windows (all bounds exclusive) and number of coins taken this tick.
   always_comb begin
      hit_s     = '0;
      hit_cnt_s = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         hit_s[i] = coin_status_r[i]
                 && ((left_s + 14'(HIT_XL)) < {1'b0, CoinFrameX[13*i +: 13]})
                 && ({1'b0, CoinFrameX[13*i +: 13]} < (left_s + 14'(HIT_XR)))
                 && ((top_s + 11'(HIT_YT)) < {1'b0, CoinY[10*i +: 10]})
                 && ({1'b0, CoinY[10*i +: 10]} < (top_s + 11'(HIT_YB)));
         hit_cnt_s = hit_cnt_s + HCW'(hit_s[i]);
      end
   end

   // Saturating score update; the sum is wide enough to never wrap before the clamp.
   always_comb begin
      score_sum_s = SUMW'(score_r) + SUMW'(hit_cnt_s);
      if (score_sum_s > SCORE_MAX) begin
         score_sat_s = {SCORE_W{1'b1}};
      end else begin
         score_sat_s = score_sum_s[SCORE_W-1:0];
      end
   end

   assign lives_dec_s = lives_r - 4'd1;

   // Next-state and next-value logic for the game FSM.
   always_comb begin
      state_next_s    = state_r;
      coin_next_s     = coin_status_r;
      level_next_s    = level_r;
      score_next_s    = score_r;
      lives_next_s    = lives_r;
      resp_cnt_next_s = resp_cnt_r;
      collide_next_s  = 1'b0;
      case (state_r)
         ST_WAIT: begin
            coin_next_s  = '1;
            score_next_s = '0;
            lives_next_s = 4'(LIVES);
            if (press_space_s) begin
               state_next_s = ST_SELECT;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_SELECT: begin
            // Only one level key can match the single keycode, so the vector is one-hot.
            if (|sel_vec_s) begin
               level_next_s = sel_vec_s;
               state_next_s = ST_PLAY;
            end else begin
               state_next_s = ST_SELECT;
            end
         end
         ST_PLAY: begin
            if (pause_key_s) begin
               state_next_s = ST_PAUSE;
            end else if (tick_s) begin
               if (dead_s) begin
                  lives_next_s = lives_dec_s;
                  if (lives_dec_s == 4'd0) begin
                     state_next_s = ST_LOSE;
                  end else begin
                     state_next_s    = ST_RESPAWN;
                     resp_cnt_next_s = '0;
                  end
               end else begin
                  coin_next_s    = coin_status_r & ~hit_s;
                  score_next_s   = score_sat_s;
                  collide_next_s = |hit_s;
                  if (win_s) begin
                     state_next_s = ST_WIN;
                  end else begin
                     state_next_s = ST_PLAY;
                  end
               end
            end else begin
               state_next_s = ST_PLAY;
            end
         end
         ST_RESPAWN: begin
            if (tick_s) begin
               if (resp_cnt_r == RCW'(RESPAWN_FRAMES - 1)) begin
                  state_next_s    = ST_PLAY;
                  resp_cnt_next_s = '0;
               end else begin
                  resp_cnt_next_s = resp_cnt_r + RCW'(1);
               end
            end else begin
               state_next_s = ST_RESPAWN;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (press_space_s) begin
               state_next_s = ST_WAIT;
               coin_next_s  = '1;
               score_next_s = '0;
               lives_next_s = 4'(LIVES);
            end else begin
               state_next_s = state_r;
            end
         end
         ST_PAUSE: begin
            if (pause_key_s) begin
               state_next_s = ST_PLAY;
            end else if (esc_key_s) begin
               state_next_s = ST_WAIT;
               coin_next_s  = '1;
               score_next_s = '0;
               lives_next_s = 4'(LIVES);
            end else begin
               state_next_s = state_r;
            end
         end
         default: begin
            state_next_s = ST_WAIT;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r       <= ST_WAIT;
         coin_status_r <= '1;
         level_r       <= NUM_LEVELS'(1);
         score_r       <= '0;
         lives_r       <= 4'(LIVES);
         resp_cnt_r    <= '0;
         collide_r     <= 1'b0;
         status_r      <= 5'b01000;
         respawn_r     <= 1'b0;
         key_prev_r    <= 8'h00;
         frame_prev_r  <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         coin_status_r <= coin_next_s;
         level_r       <= level_next_s;
         score_r       <= score_next_s;
         lives_r       <= lives_next_s;
         resp_cnt_r    <= resp_cnt_next_s;
         collide_r     <= collide_next_s;
         status_r      <= status_of(state_next_s);
         respawn_r     <= (state_next_s == ST_RESPAWN);
         key_prev_r    <= keycode;
         frame_prev_r  <= frame_clk;
      end
   end

   assign CoinStatus   = coin_status_r;
   assign level_status = level_r;
   assign status       = status_r;
   assign coin_collide = collide_r;
   assign score        = score_r;
   assign lives_left   = lives_r;
   assign respawn      = respawn_r;

endmodule

// File: tb/tb_game_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl_param
// Directed bench for game_ctrl_param. Instance a uses default parameters;
// instance b uses five coins and a 2-bit score to exercise saturation.
// -----------------------------------------------------------------------------
module tb_game_ctrl_param;

   localparam logic [4:0] S_SELECT = 5'b10000;
   localparam logic [4:0] S_WAIT   = 5'b01000;
   localparam logic [4:0] S_PLAY   = 5'b00100;
   localparam logic [4:0] S_WIN    = 5'b00010;
   localparam logic [4:0] S_LOSE   = 5'b00001;

   logic        Clk = 1'b0;
   logic        Reset, Reset_b;
   logic        frame_clk;
   logic [7:0]  keycode;
   logic [9:0]  StickmanTop, GroundY;
   logic [11:0] frame_counter;

   logic [38:0] CoinFrameX;
   logic [29:0] CoinY;
   logic [2:0]  CoinStatus;
   logic [1:0]  level_status;
   logic [4:0]  status;
   logic        coin_collide;
   logic [7:0]  score;
   logic [3:0]  lives_left;
   logic        respawn;

   logic [64:0] CoinFrameX_b;
   logic [49:0] CoinY_b;
   logic [4:0]  CoinStatus_b;
   logic [1:0]  level_status_b;
   logic [4:0]  status_b;
   logic        coin_collide_b;
   logic [1:0]  score_b;
   logic [3:0]  lives_left_b;
   logic        respawn_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   game_ctrl_param dut_a (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .StickmanTop(StickmanTop), .GroundY(GroundY), .frame_counter(frame_counter),
      .CoinFrameX(CoinFrameX), .CoinY(CoinY), .CoinStatus(CoinStatus),
      .level_status(level_status), .status(status), .coin_collide(coin_collide),
      .score(score), .lives_left(lives_left), .respawn(respawn)
   );

   game_ctrl_param #(.NUM_COINS(5), .SCORE_W(2)) dut_b (
      .Clk(Clk), .Reset(Reset_b), .frame_clk(frame_clk), .keycode(keycode),
      .StickmanTop(StickmanTop), .GroundY(GroundY), .frame_counter(frame_counter),
      .CoinFrameX(CoinFrameX_b), .CoinY(CoinY_b), .CoinStatus(CoinStatus_b),
      .level_status(level_status_b), .status(status_b), .coin_collide(coin_collide_b),
      .score(score_b), .lives_left(lives_left_b), .respawn(respawn_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_tick;
      frame_clk = 1'b1;
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   task automatic press_key(input logic [7:0] k);
      keycode = k;
      @(negedge Clk);
      keycode = 8'h00;
      @(negedge Clk);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int         entries;
      logic [4:0] prev;
      Reset = 1'b1; Reset_b = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
      StickmanTop = 10'd200; GroundY = 10'd300; frame_counter = 12'd0;
      CoinFrameX = '0; CoinY = '0; CoinFrameX_b = '0; CoinY_b = '0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset / idle state
      check("rst_status",  32'(status),       32'(S_WAIT));
      check("rst_coins",   32'(CoinStatus),   32'h7);
      check("rst_level",   32'(level_status), 32'h1);
      check("rst_lives",   32'(lives_left),   32'd3);
      check("rst_score",   32'(score),        32'd0);
      check("rst_respawn", 32'(respawn),      32'd0);
      check("rst_collide", 32'(coin_collide), 32'd0);

      // Space held 10 cycles: exactly one SELECT entry
      entries = 0;
      prev    = status;
      keycode = 8'h2C;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (status == S_SELECT && prev != S_SELECT) entries++;
         prev = status;
      end
      keycode = 8'h00;
      @(negedge Clk);
      check("select_entries", 32'(entries), 32'd1);
      check("select_status",  32'(status),  32'(S_SELECT));
      press_key(8'h1F);
      check("lvl1_level",  32'(level_status), 32'h2);
      check("lvl1_status", 32'(status),       32'(S_PLAY));

      // 'P' is ignored without the pause build
      press_key(8'h13);
      check("p_ignored", 32'(status), 32'(S_PLAY));

      // Death -> RESPAWN for 60 ticks -> PLAY, repeated until LOSE
      StickmanTop = 10'd400; GroundY = 10'd440;
      do_tick;
      check("die1_lives",   32'(lives_left), 32'd2);
      check("die1_respawn", 32'(respawn),    32'd1);
      check("die1_status",  32'(status),     32'(S_PLAY));
      repeat (59) do_tick;
      check("resp59_respawn", 32'(respawn), 32'd1);
      do_tick;
      check("resp60_respawn", 32'(respawn), 32'd0);
      check("resp60_status",  32'(status),  32'(S_PLAY));
      do_tick;
      check("die2_lives", 32'(lives_left), 32'd1);
      repeat (60) do_tick;
      check("resp2_respawn", 32'(respawn), 32'd0);
      do_tick;
      check("die3_lives",  32'(lives_left), 32'd0);
      check("lose_status", 32'(status),     32'(S_LOSE));
      do_tick;
      check("lose_frozen", 32'(status), 32'(S_LOSE));

      // LOSE -> WAIT -> SELECT -> level 0
      press_key(8'h2C);
      check("lose_wait",  32'(status),     32'(S_WAIT));
      check("wait_lives", 32'(lives_left), 32'd3);
      press_key(8'h2C);
      press_key(8'h1E);
      check("lvl0_level",  32'(level_status), 32'h1);
      check("lvl0_status", 32'(status),       32'(S_PLAY));

      // Coin pickup in slot 1
      frame_counter = 12'd200; StickmanTop = 10'd200; GroundY = 10'd300;
      CoinFrameX = {13'd0, 13'd320, 13'd0};
      CoinY      = {10'd0, 10'd250, 10'd0};
      frame_clk = 1'b1;
      @(negedge Clk);
      frame_clk = 1'b0;
      check("coin_collide_hi", 32'(coin_collide), 32'd1);
      check("coin_status",     32'(CoinStatus),   32'h5);
      check("coin_score",      32'(score),        32'd1);
      @(negedge Clk);
      check("coin_collide_lo", 32'(coin_collide), 32'd0);
      frame_clk = 1'b1;
      @(negedge Clk);
      frame_clk = 1'b0;
      check("coin2_collide", 32'(coin_collide), 32'd0);
      check("coin2_status",  32'(CoinStatus),   32'h5);
      check("coin2_score",   32'(score),        32'd1);
      @(negedge Clk);

      // Death beats win at frame 3000
      frame_counter = 12'd3000; StickmanTop = 10'd400; GroundY = 10'd440;
      do_tick;
      check("dwin_status",  32'(status),     32'(S_PLAY));
      check("dwin_lives",   32'(lives_left), 32'd2);
      check("dwin_respawn", 32'(respawn),    32'd1);
      repeat (60) do_tick;
      StickmanTop = 10'd200; GroundY = 10'd300;
      do_tick;
      check("win_status", 32'(status), 32'(S_WIN));
      check("win_score",  32'(score),  32'd1);
      press_key(8'h2C);
      check("win_wait",   32'(status),     32'(S_WAIT));
      check("win_coins",  32'(CoinStatus), 32'h7);
      check("win_score0", 32'(score),      32'd0);
      check("win_lives",  32'(lives_left), 32'd3);

      // Instance b: 2-bit score saturation with five coins
      Reset_b = 1'b0;
      frame_counter = 12'd0;
      @(negedge Clk);
      press_key(8'h2C);
      press_key(8'h1E);
      check("b_status", 32'(status_b), 32'(S_PLAY));
      CoinFrameX_b = {13'd0, 13'd0, 13'd0, 13'd120, 13'd120};
      CoinY_b      = {5{10'd250}};
      do_tick;
      check("b_score2", 32'(score_b),      32'd2);
      check("b_coins2", 32'(CoinStatus_b), 32'h1C);
      CoinFrameX_b = {5{13'd120}};
      do_tick;
      check("b_score_sat", 32'(score_b),      32'd3);
      check("b_coins0",    32'(CoinStatus_b), 32'h00);

      // Reset while respawning
      StickmanTop = 10'd400; GroundY = 10'd440;
      do_tick;
      check("b_respawn", 32'(respawn_b),    32'd1);
      check("b_lives",   32'(lives_left_b), 32'd2);
      Reset_b = 1'b1;
      @(negedge Clk);
      Reset_b = 1'b0;
      check("b_rst_status",  32'(status_b),     32'(S_WAIT));
      check("b_rst_coins",   32'(CoinStatus_b), 32'h1F);
      check("b_rst_score",   32'(score_b),      32'd0);
      check("b_rst_lives",   32'(lives_left_b), 32'd3);
      check("b_rst_respawn", 32'(respawn_b),    32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
